// File: rtl/cardinal_router_node_vc_pkg.sv
// Shared constants for the cardinal mesh node: port indices, header bit
// positions (functions of flit and hop-field width) and routing-mode codes.
package cardinal_router_node_vc_pkg;

    localparam int NP = 5;

    localparam logic [2:0] P_N  = 3'd0;
    localparam logic [2:0] P_S  = 3'd1;
    localparam logic [2:0] P_E  = 3'd2;
    localparam logic [2:0] P_W  = 3'd3;
    localparam logic [2:0] P_PE = 3'd4;

    localparam int ROUTE_XY = 0;
    localparam int ROUTE_YX = 1;

    function automatic int vc_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int dx_bit(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int dy_bit(input int data_w);
        return data_w - 3;
    endfunction

    function automatic int hx_msb(input int data_w);
        return data_w - 4;
    endfunction

    function automatic int hy_msb(input int data_w, input int hop_w);
        return data_w - 4 - hop_w;
    endfunction

    // Round-robin successor over N,S,E,W,PE.
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        return (idx == P_PE) ? P_N : idx + 3'd1;
    endfunction

endpackage

// File: rtl/cardinal_router_node_vc_fifo.sv
// Single-VC input FIFO with exact count. Writes are dropped when full and
// reads are ignored when empty.
module cardinal_vc_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Next pointers and occupancy.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // Pointer/count state; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cardinal_router_node_vc.sv
// Five-port cardinal mesh node with two polarity-interleaved virtual
// channels, per-input per-VC FIFOs, dimension-ordered routing and a
// round-robin switch per output.
//
// Link handshake: in a cycle of polarity p the links carry VC ~p. An
// upstream flit transfers at the clock edge when <d>_si && <d>_ri; <d>_ri
// depends only on the FIFO occupancy, never on <d>_si. Downstream, <d>_so
// is already qualified by <d>_ro, so <d>_so high means the flit on <d>_do
// is taken at that edge. si while ri is low is dropped.
module cardinal_router_node_vc
    import cardinal_router_node_vc_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 2,
    parameter int HOP_W      = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n_si,
    input  logic [DATA_W-1:0] n_di,
    output logic              n_ri,
    output logic              n_so,
    output logic [DATA_W-1:0] n_do,
    input  logic              n_ro,
    input  logic              s_si,
    input  logic [DATA_W-1:0] s_di,
    output logic              s_ri,
    output logic              s_so,
    output logic [DATA_W-1:0] s_do,
    input  logic              s_ro,
    input  logic              e_si,
    input  logic [DATA_W-1:0] e_di,
    output logic              e_ri,
    output logic              e_so,
    output logic [DATA_W-1:0] e_do,
    input  logic              e_ro,
    input  logic              w_si,
    input  logic [DATA_W-1:0] w_di,
    output logic              w_ri,
    output logic              w_so,
    output logic [DATA_W-1:0] w_do,
    input  logic              w_ro,
    input  logic              pe_si,
    input  logic [DATA_W-1:0] pe_di,
    output logic              pe_ri,
    output logic              pe_so,
    output logic [DATA_W-1:0] pe_do,
    input  logic              pe_ro,
    output logic              polarity
);

    localparam int CW     = $clog2(DEPTH + 1);
    localparam int NB     = 2 * NP;
    localparam int DX_BIT = dx_bit(DATA_W);
    localparam int DY_BIT = dy_bit(DATA_W);
    localparam int HX_MSB = hx_msb(DATA_W);
    localparam int HY_MSB = hy_msb(DATA_W, HOP_W);

    logic              polarity_q, polarity_d, npol;
    logic [NP-1:0]     si_w, ri_w, so_w, ro_w;
    logic [DATA_W-1:0] di_w [NP];
    logic [DATA_W-1:0] do_w [NP];

    // FIFO and output-register slot b = 2*port + vc.
    logic [NB-1:0]     push, pop, full, empty;
    logic [DATA_W-1:0] head [NB];
    logic [CW-1:0]     cnt  [NB];

    logic [2:0]        rdir  [NP];
    logic [DATA_W-1:0] rflit [NP];

    logic [NB-1:0]     or_valid_q, or_valid_d;
    logic [DATA_W-1:0] or_data_q [NB];
    logic [DATA_W-1:0] or_data_d [NB];
    logic [2:0]        ptr_q  [NP];
    logic [2:0]        ptr_d  [NP];
    logic [DATA_W-1:0] last_q [NP];
    logic [DATA_W-1:0] last_d [NP];

    assign si_w = {pe_si, w_si, e_si, s_si, n_si};
    assign ro_w = {pe_ro, w_ro, e_ro, s_ro, n_ro};
    assign di_w[P_N]  = n_di;
    assign di_w[P_S]  = s_di;
    assign di_w[P_E]  = e_di;
    assign di_w[P_W]  = w_di;
    assign di_w[P_PE] = pe_di;

    assign {pe_ri, w_ri, e_ri, s_ri, n_ri} = ri_w;
    assign {pe_so, w_so, e_so, s_so, n_so} = so_w;
    assign n_do  = do_w[P_N];
    assign s_do  = do_w[P_S];
    assign e_do  = do_w[P_E];
    assign w_do  = do_w[P_W];
    assign pe_do = do_w[P_PE];

    assign polarity   = polarity_q;
    assign npol       = ~polarity_q;
    assign polarity_d = ~polarity_q;

    for (genvar g = 0; g < NP; g++) begin : g_in
        for (genvar v = 0; v < 2; v++) begin : g_vc
            cardinal_vc_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push_i    (push[2*g+v]),
                .wr_data_i (di_w[g]),
                .pop_i     (pop[2*g+v]),
                .rd_data_o (head[2*g+v]),
                .count_o   (cnt[2*g+v]),
                .full_o    (full[2*g+v]),
                .empty_o   (empty[2*g+v])
            );
        end
    end

    // Ingress: links feed the VC that is not being switched this cycle.
    always_comb begin
        ri_w = '0;
        push = '0;
        for (int i = 0; i < NP; i++) begin
            ri_w[i] = (cnt[2*i + int'(npol)] != CW'(DEPTH));
            push[2*i + int'(npol)] = si_w[i] && !full[2*i + int'(npol)];
        end
    end

    // Route compute on the head of each input's switching VC.
    always_comb begin
        logic [DATA_W-1:0] hd;
        logic [HOP_W-1:0]  hx, hy;
        logic              use_x, use_y;
        hd    = '0;
        hx    = '0;
        hy    = '0;
        use_x = 1'b0;
        use_y = 1'b0;
        for (int i = 0; i < NP; i++) begin
            hd = head[2*i + int'(polarity_q)];
            hx = hd[HX_MSB -: HOP_W];
            hy = hd[HY_MSB -: HOP_W];
            if (ROUTE_MODE == ROUTE_YX) begin
                use_y = (hy != '0);
                use_x = (hy == '0) && (hx != '0);
            end else begin
                use_x = (hx != '0);
                use_y = (hx == '0) && (hy != '0);
            end
            rdir[i]  = P_PE;
            rflit[i] = hd;
            if (use_x) begin
                rdir[i] = hd[DX_BIT] ? P_W : P_E;
                rflit[i][HX_MSB -: HOP_W] = hx - 1'b1;
            end else if (use_y) begin
                rdir[i] = hd[DY_BIT] ? P_S : P_N;
                rflit[i][HY_MSB -: HOP_W] = hy - 1'b1;
            end
        end
    end

    // Egress: drive the opposite-VC output register; data holds when idle.
    always_comb begin
        so_w = '0;
        for (int o = 0; o < NP; o++) begin
            so_w[o] = or_valid_q[2*o + int'(npol)] && ro_w[o];
            do_w[o] = so_w[o] ? or_data_q[2*o + int'(npol)] : last_q[o];
        end
    end

    // Switch: per-output round-robin grant into the switching-VC register,
    // plus clearing of registers drained by egress.
    always_comb begin
        logic found;
        int   win;
        int   idx;
        found      = 1'b0;
        win        = 0;
        idx        = 0;
        pop        = '0;
        or_valid_d = or_valid_q;
        for (int b = 0; b < NB; b++) or_data_d[b] = or_data_q[b];
        for (int o = 0; o < NP; o++) begin
            ptr_d[o]  = ptr_q[o];
            last_d[o] = last_q[o];
        end
        for (int o = 0; o < NP; o++) begin
            if (so_w[o]) begin
                or_valid_d[2*o + int'(npol)] = 1'b0;
                last_d[o] = or_data_q[2*o + int'(npol)];
            end
            found = 1'b0;
            win   = 0;
            if (!or_valid_q[2*o + int'(polarity_q)]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= NP) idx = idx - NP;
                    if (!found && !empty[2*idx + int'(polarity_q)] &&
                        (rdir[idx] == 3'(o))) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    or_valid_d[2*o + int'(polarity_q)] = 1'b1;
                    or_data_d[2*o + int'(polarity_q)]  = rflit[win];
                    pop[2*win + int'(polarity_q)]      = 1'b1;
                    ptr_d[o] = rr_next(3'(win));
                end
            end
        end
    end

    // Node state; reset discards every buffered flit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q <= 1'b0;
            or_valid_q <= '0;
            for (int b = 0; b < NB; b++) or_data_q[b] <= '0;
            for (int o = 0; o < NP; o++) begin
                ptr_q[o]  <= P_N;
                last_q[o] <= '0;
            end
        end else begin
            polarity_q <= polarity_d;
            or_valid_q <= or_valid_d;
            for (int b = 0; b < NB; b++) or_data_q[b] <= or_data_d[b];
            for (int o = 0; o < NP; o++) begin
                ptr_q[o]  <= ptr_d[o];
                last_q[o] <= last_d[o];
            end
        end
    end

endmodule

// File: tb/tb_cardinal_router_node_vc.sv
// Directed bench for cardinal_router_node_vc: one XY node and one YX node
// sharing clock and reset.
module tb_cardinal_router_node_vc;

    localparam int DW = 64;
    localparam int N  = 0;
    localparam int S  = 1;
    localparam int E  = 2;
    localparam int W  = 3;
    localparam int PE = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]    si, ro, ri, so;
    logic [DW-1:0] di [5];
    logic [DW-1:0] dout [5];
    logic          pol;

    logic [4:0]    y_si, y_ro, y_ri, y_so;
    logic [DW-1:0] y_di [5];
    logic [DW-1:0] y_dout [5];
    logic          y_pol;

    logic exp_pol;
    int   n_pass  = 0;
    int   n_total = 0;

    cardinal_router_node_vc #(.DATA_W(DW), .DEPTH(2), .HOP_W(4), .ROUTE_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .n_si(si[N]),   .n_di(di[N]),   .n_ri(ri[N]),   .n_so(so[N]),   .n_do(dout[N]),   .n_ro(ro[N]),
        .s_si(si[S]),   .s_di(di[S]),   .s_ri(ri[S]),   .s_so(so[S]),   .s_do(dout[S]),   .s_ro(ro[S]),
        .e_si(si[E]),   .e_di(di[E]),   .e_ri(ri[E]),   .e_so(so[E]),   .e_do(dout[E]),   .e_ro(ro[E]),
        .w_si(si[W]),   .w_di(di[W]),   .w_ri(ri[W]),   .w_so(so[W]),   .w_do(dout[W]),   .w_ro(ro[W]),
        .pe_si(si[PE]), .pe_di(di[PE]), .pe_ri(ri[PE]), .pe_so(so[PE]), .pe_do(dout[PE]), .pe_ro(ro[PE]),
        .polarity(pol)
    );

    cardinal_router_node_vc #(.DATA_W(DW), .DEPTH(2), .HOP_W(4), .ROUTE_MODE(1)) dut_yx (
        .clk(clk), .reset(reset),
        .n_si(y_si[N]),   .n_di(y_di[N]),   .n_ri(y_ri[N]),   .n_so(y_so[N]),   .n_do(y_dout[N]),   .n_ro(y_ro[N]),
        .s_si(y_si[S]),   .s_di(y_di[S]),   .s_ri(y_ri[S]),   .s_so(y_so[S]),   .s_do(y_dout[S]),   .s_ro(y_ro[S]),
        .e_si(y_si[E]),   .e_di(y_di[E]),   .e_ri(y_ri[E]),   .e_so(y_so[E]),   .e_do(y_dout[E]),   .e_ro(y_ro[E]),
        .w_si(y_si[W]),   .w_di(y_di[W]),   .w_ri(y_ri[W]),   .w_so(y_so[W]),   .w_do(y_dout[W]),   .w_ro(y_ro[W]),
        .pe_si(y_si[PE]), .pe_di(y_di[PE]), .pe_ri(y_ri[PE]), .pe_so(y_so[PE]), .pe_do(y_dout[PE]), .pe_ro(y_ro[PE]),
        .polarity(y_pol)
    );

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] mk(input logic vc, input logic dx, input logic dy,
                                         input logic [3:0] hx, input logic [3:0] hy,
                                         input logic [52:0] pay);
        return {vc, dx, dy, hx, hy, pay};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; the bench's own polarity model toggles only out of reset.
    task automatic tick();
        @(posedge clk);
        if (reset) exp_pol = ~exp_pol;
        #1;
    endtask

    task automatic wait_pol(input logic v);
        if (exp_pol != v) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        si = '0; ro = '1; y_si = '0; y_ro = '1;
        for (int i = 0; i < 5; i++) begin
            di[i]   = '0;
            y_di[i] = '0;
        end
        exp_pol = 1'b0;

        // Reset with all inputs idle.
        #1 reset = 1'b0;
        #2;
        check("rst_pol", pol, 1'b0);
        check("rst_so", so, 5'b00000);
        check("rst_ri", ri, 5'b11111);
        check("rst_e_do", dout[E], '0);
        check("rst_yx_so", y_so, 5'b00000);
        tick();
        tick();
        check("rst_held_pol", pol, 1'b0);
        reset = 1'b1;
        check("pol_t0", pol, exp_pol);
        tick();
        check("pol_t1", pol, 1'b1);
        tick();
        check("pol_t2", pol, 1'b0);
        tick();
        check("pol_t3", pol, 1'b1);
        check("yx_pol", y_pol, exp_pol);
        check("idle_ri", ri, 5'b11111);
        check("idle_so", so, 5'b00000);

        // Contention: n, s, pe each send a VC-0 flit East.
        wait_pol(1'b1);
        si[N]  = 1'b1; di[N]  = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 53'h111);
        si[S]  = 1'b1; di[S]  = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 53'h222);
        si[PE] = 1'b1; di[PE] = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 53'h333);
        check("cont_ri", ri, 5'b11111);
        tick();
        si = '0;
        check("cont_slot0_idle", so[E], 1'b0);
        tick();
        check("cont_n_so", so[E], 1'b1);
        check("cont_n_do", dout[E], mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 53'h111));
        tick();
        check("cont_gap1", so[E], 1'b0);
        tick();
        check("cont_s_so", so[E], 1'b1);
        check("cont_s_do", dout[E], mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 53'h222));
        tick();
        check("cont_gap2", so[E], 1'b0);
        tick();
        check("cont_pe_so", so[E], 1'b1);
        check("cont_pe_do", dout[E], mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 53'h333));
        tick();
        check("cont_done", so, 5'b00000);

        // XY single hop West -> East.
        wait_pol(1'b0);
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'h5A5A);
        check("xy_ri", ri[W], 1'b1);
        tick();
        si = '0;
        check("xy_lat1", so, 5'b00000);
        tick();
        check("xy_so", so, 5'b00100);
        check("xy_do", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 53'h5A5A));
        tick();
        check("xy_so_clear", so[E], 1'b0);
        check("xy_do_held", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 53'h5A5A));

        // YX node: PE flit with HX=2, HY=1, Dy=South.
        wait_pol(1'b0);
        y_si[PE] = 1'b1; y_di[PE] = mk(1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 53'h777);
        tick();
        y_si = '0;
        tick();
        check("yx_so", y_so, 5'b00010);
        check("yx_do", y_dout[S], mk(1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 53'h777));
        tick();

        // Backpressure on East, VC-1 flits from West.
        ro[E] = 1'b0;
        wait_pol(1'b0);
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hB1);
        check("bp_ri1", ri[W], 1'b1);
        tick();
        si = '0;
        tick();
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hB2);
        check("bp_ri2", ri[W], 1'b1);
        tick();
        si = '0;
        check("bp_blocked", so[E], 1'b0);
        tick();
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hB3);
        check("bp_ri3", ri[W], 1'b1);
        tick();
        si = '0;
        tick();
        check("bp_full_ri", ri[W], 1'b0);
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hB4);
        tick();
        si = '0;
        tick();
        check("bp_full_ri_kept", ri[W], 1'b0);
        ro[E] = 1'b1;
        #1;
        check("bp_out1_so", so[E], 1'b1);
        check("bp_out1_do", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 53'hB1));
        tick();
        check("bp_gap", so[E], 1'b0);
        tick();
        check("bp_out2_so", so[E], 1'b1);
        check("bp_out2_do", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 53'hB2));
        tick();
        tick();
        check("bp_out3_so", so[E], 1'b1);
        check("bp_out3_do", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 53'hB3));
        check("bp_ri_free", ri[W], 1'b1);
        tick();
        tick();
        check("bp_no_dropped", so[E], 1'b0);

        // Asynchronous reset with buffered flits.
        ro[E] = 1'b0;
        wait_pol(1'b0);
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hA1);
        tick();
        si = '0;
        tick();
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hA2);
        tick();
        si = '0;
        tick();
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 53'hA3);
        tick();
        si = '0;
        tick();
        check("ar_pre_ri", ri[W], 1'b0);
        ro[E] = 1'b1;
        #1;
        check("ar_pre_so", so[E], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_so", so, 5'b00000);
        check("ar_do", dout[E], '0);
        check("ar_ri", ri, 5'b11111);
        check("ar_pol", pol, 1'b0);
        exp_pol = 1'b0;
        tick();
        check("ar_held_ri", ri, 5'b11111);
        check("ar_held_pol", pol, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_no_stale", so, 5'b00000);
        end
        check("ar_pol_after", pol, exp_pol);

        // Node still works after reset.
        wait_pol(1'b0);
        si[W] = 1'b1; di[W] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 53'hC0DE);
        tick();
        si = '0;
        tick();
        check("post_rst_so", so, 5'b00100);
        check("post_rst_do", dout[E], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 53'hC0DE));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
